// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: shifts WIDTH-bit words out MSB-first with an optional idle gap.
// Define SERIAL_BIT_FEEDER_PARITY_EN to append an even-parity bit after the LSB.
module serial_bit_feeder #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned GAP_CYCLES = 0,
    parameter logic        IDLE_BIT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy
);

`ifdef SERIAL_BIT_FEEDER_PARITY_EN
    localparam int unsigned NBITS = WIDTH + 1;
`else
    localparam int unsigned NBITS = WIDTH;
`endif
    localparam int unsigned CW = $clog2(NBITS + 1);
    localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CW-1:0] CNT_LOAD = CW'(NBITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t            state_q, state_d;
    logic [NBITS-1:0]  sr_q, sr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              ser_out_q, ser_out_d;
    logic              ser_valid_q, ser_valid_d;
    logic              word_done_q, word_done_d;
    logic              busy_q, busy_d;
    logic [NBITS-1:0]  load_word;
    logic              accept;

`ifdef SERIAL_BIT_FEEDER_PARITY_EN
    assign load_word = {in_data, ^in_data};
`else
    assign load_word = in_data;
`endif

    // Ready depends only on state and counter so upstream never sees a loop through in_valid.
    assign in_ready = (state_q == IDLE) ||
                      ((GAP_CYCLES == 0) && (state_q == SHIFT) && (cnt_q == '0));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        ser_out_d   = ser_out_q;
        ser_valid_d = ser_valid_q;
        word_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = SHIFT;
                    sr_d        = load_word << 1;
                    cnt_d       = CNT_LOAD;
                    ser_out_d   = load_word[NBITS-1];
                    ser_valid_d = 1'b1;
                end
            end
            SHIFT: begin
                // The bit on ser_out now is already presented; sr_q holds the remaining bits.
                if (cnt_q != '0) begin
                    ser_out_d   = sr_q[NBITS-1];
                    sr_d        = sr_q << 1;
                    cnt_d       = cnt_q - CW'(1);
                    word_done_d = (cnt_q == CW'(1));
                end else if (GAP_CYCLES != 0) begin
                    state_d     = GAP;
                    gap_d       = GAP_LOAD;
                    ser_out_d   = IDLE_BIT;
                    ser_valid_d = 1'b0;
                end else if (accept) begin
                    sr_d        = load_word << 1;
                    cnt_d       = CNT_LOAD;
                    ser_out_d   = load_word[NBITS-1];
                    ser_valid_d = 1'b1;
                end else begin
                    state_d     = IDLE;
                    ser_out_d   = IDLE_BIT;
                    ser_valid_d = 1'b0;
                end
            end
            GAP: begin
                ser_out_d   = IDLE_BIT;
                ser_valid_d = 1'b0;
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                ser_out_d   = IDLE_BIT;
                ser_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            ser_out_q   <= IDLE_BIT;
            ser_valid_q <= 1'b0;
            word_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            word_done_q <= word_done_d;
            busy_q      <= busy_d;
        end
    end

    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign word_done = word_done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: instance 0 runs back-to-back (no gap), instance 1 inserts a 2-cycle gap.
module tb_serial_bit_feeder;

`ifdef SERIAL_BIT_FEEDER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] in_valid;
    logic [1:0] in_ready;
    logic [7:0] in_data [2];
    logic [1:0] ser_out;
    logic [1:0] ser_valid;
    logic [1:0] word_done;
    logic [1:0] busy;

    int n_assert;
    int n_fail;

    serial_bit_feeder #(.WIDTH(8), .GAP_CYCLES(0), .IDLE_BIT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .ser_out(ser_out[0]), .ser_valid(ser_valid[0]),
        .word_done(word_done[0]), .busy(busy[0])
    );

    serial_bit_feeder #(.WIDTH(8), .GAP_CYCLES(2), .IDLE_BIT(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .ser_out(ser_out[1]), .ser_valid(ser_valid[1]),
        .word_done(word_done[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bit i of the serial image of word d: MSB first, then even parity when enabled.
    function automatic logic exp_bit(input logic [7:0] d, input int i);
        logic [7:0] w;
        w = d;
        if (i < 8) return w[7-i];
        return ^w;
    endfunction

    task automatic chk_idle(input int s, input string tag);
        chk({tag, "_valid"}, 32'(ser_valid[s]), 32'd0);
        chk({tag, "_out"},   32'(ser_out[s]),   32'd0);
        chk({tag, "_busy"},  32'(busy[s]),      32'd0);
        chk({tag, "_ready"}, 32'(in_ready[s]),  32'd1);
        chk({tag, "_done"},  32'(word_done[s]), 32'd0);
    endtask

    // Single word: handshake, then in_data is scrambled while busy to show it is ignored.
    task automatic run_word(input int s, input logic [7:0] d, input string tag);
        chk({tag, "_rdy_pre"}, 32'(in_ready[s]), 32'd1);
        in_data[s]  = d;
        in_valid[s] = 1'b1;
        step();
        in_valid[s] = 1'b0;
        in_data[s]  = ~d;
        for (int i = 0; i < NB; i++) begin
            chk($sformatf("%s_bit%0d", tag, i), 32'(ser_out[s]), 32'(exp_bit(d, i)));
            chk($sformatf("%s_vld%0d", tag, i), 32'(ser_valid[s]), 32'd1);
            chk($sformatf("%s_done%0d", tag, i), 32'(word_done[s]), 32'(i == NB - 1));
            chk($sformatf("%s_busy%0d", tag, i), 32'(busy[s]), 32'd1);
            step();
        end
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        in_valid    = '0;
        in_data[0]  = '0;
        in_data[1]  = '0;
        #12;
        chk_idle(0, "rst0");
        chk_idle(1, "rst1");
        rst_n = 1'b1;
        step();

        // Single word E5 on the no-gap instance.
        run_word(0, 8'hE5, "e5");
        chk_idle(0, "e5_post");
        step();

        // Back-to-back FF then 00 with in_valid held; data flips early to prove it's ignored until ready.
        in_data[0]  = 8'hFF;
        in_valid[0] = 1'b1;
        step();
        for (int i = 0; i < NB; i++) begin
            if (i == 0) in_data[0] = 8'h00;
            chk($sformatf("b2b_a_bit%0d", i), 32'(ser_out[0]), 32'(exp_bit(8'hFF, i)));
            chk($sformatf("b2b_a_vld%0d", i), 32'(ser_valid[0]), 32'd1);
            chk($sformatf("b2b_a_done%0d", i), 32'(word_done[0]), 32'(i == NB - 1));
            chk($sformatf("b2b_a_rdy%0d", i), 32'(in_ready[0]), 32'(i == NB - 1));
            step();
        end
        for (int i = 0; i < NB; i++) begin
            if (i == 0) in_valid[0] = 1'b0;
            chk($sformatf("b2b_b_bit%0d", i), 32'(ser_out[0]), 32'(exp_bit(8'h00, i)));
            chk($sformatf("b2b_b_vld%0d", i), 32'(ser_valid[0]), 32'd1);
            chk($sformatf("b2b_b_done%0d", i), 32'(word_done[0]), 32'(i == NB - 1));
            step();
        end
        chk_idle(0, "b2b_post");

        // Gap instance: A5 then 3C with in_valid held throughout.
        in_data[1]  = 8'hA5;
        in_valid[1] = 1'b1;
        step();
        for (int i = 0; i < NB; i++) begin
            if (i == 0) in_data[1] = 8'h3C;
            chk($sformatf("gap_a_bit%0d", i), 32'(ser_out[1]), 32'(exp_bit(8'hA5, i)));
            chk($sformatf("gap_a_vld%0d", i), 32'(ser_valid[1]), 32'd1);
            chk($sformatf("gap_a_rdy%0d", i), 32'(in_ready[1]), 32'd0);
            chk($sformatf("gap_a_done%0d", i), 32'(word_done[1]), 32'(i == NB - 1));
            step();
        end
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("gap_vld%0d", g), 32'(ser_valid[1]), 32'd0);
            chk($sformatf("gap_out%0d", g), 32'(ser_out[1]), 32'd0);
            chk($sformatf("gap_busy%0d", g), 32'(busy[1]), 32'd1);
            chk($sformatf("gap_rdy%0d", g), 32'(in_ready[1]), 32'd0);
            step();
        end
        chk("gap_idle_vld", 32'(ser_valid[1]), 32'd0);
        chk("gap_idle_busy", 32'(busy[1]), 32'd0);
        chk("gap_idle_rdy", 32'(in_ready[1]), 32'd1);
        step();
        in_valid[1] = 1'b0;
        for (int i = 0; i < NB; i++) begin
            chk($sformatf("gap_b_bit%0d", i), 32'(ser_out[1]), 32'(exp_bit(8'h3C, i)));
            chk($sformatf("gap_b_vld%0d", i), 32'(ser_valid[1]), 32'd1);
            chk($sformatf("gap_b_done%0d", i), 32'(word_done[1]), 32'(i == NB - 1));
            step();
        end
        chk("gap_b_post_vld", 32'(ser_valid[1]), 32'd0);
        chk("gap_b_post_busy", 32'(busy[1]), 32'd1);
        step();
        step();
        chk_idle(1, "gap_post");

        // Reset asynchronously after the third bit of E5.
        in_data[0]  = 8'hE5;
        in_valid[0] = 1'b1;
        step();
        in_valid[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rstmid_bit%0d", i), 32'(ser_out[0]), 32'(exp_bit(8'hE5, i)));
            if (i < 2) step();
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk_idle(0, "rstmid");
        #2;
        rst_n = 1'b1;
        step();
        chk_idle(0, "rstmid_rel");
        run_word(0, 8'h81, "w81");
        chk_idle(0, "w81_post");

        // Parity 0 case in parity builds; plain data check otherwise.
        run_word(0, 8'h03, "w03");
        chk_idle(0, "w03_post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
